tmds_multi_encoder: RTL and testbench

Parametrised multi-channel TMDS/HDMI symbol encoder: one instance encodes all NUM_CH lanes of a link. Each lane is independently in control, video, TERC4 data-island or guard-band mode. The block is a two-stage, clock-enable-qualified pipeline with per-lane running-disparity DC balancing. It sits between the video timing/packet generator and the 10:1 serializers.

---
 rtl/tmds_multi_encoder.sv | 145 ++++++++++++++
 tb/tb_tmds_multi_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_multi_encoder.sv
// Multi-lane TMDS/HDMI symbol encoder: control, video (DVI balanced), TERC4 and guard band.
// Two ce-qualified pipeline stages per lane; each lane keeps its own running disparity.
module tmds_multi_encoder #(
  parameter int NUM_CH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [2*NUM_CH-1:0]  mode,
  input  logic [8*NUM_CH-1:0]  vd,
  input  logic [2*NUM_CH-1:0]  cd,
  input  logic [4*NUM_CH-1:0]  terc,
  output logic [10*NUM_CH-1:0] tmds
);

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'b00,
    MODE_VIDEO = 2'b01,
    MODE_TERC  = 2'b10,
    MODE_GUARD = 2'b11
  } mode_e;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < 8; k++) n = n + 4'(d[k]);
    return n;
  endfunction

  // Transition-minimising first stage: XNOR chain when the byte is ones-heavy.
  function automatic logic [8:0] make_qm(input logic [7:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n        = popcount8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int k = 1; k < 8; k++)
      q[k] = use_xnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] t);
    logic [9:0] s;
    unique case (t)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'hA: s = 10'b0110011100;
      4'hB: s = 10'b1011000110;
      4'hC: s = 10'b1010001110;
      4'hD: s = 10'b1001110001;
      4'hE: s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    localparam logic [9:0] GUARD_SYM = ((i % 2) == 0) ? 10'b1011001100 : 10'b0100110011;

    mode_e             mode_q;
    logic [1:0]        cd_q;
    logic [3:0]        terc_q;
    logic [8:0]        qm_q;
    logic [3:0]        n1;
    logic signed [4:0] diff;
    logic signed [4:0] cnt_q, cnt_d;
    logic [9:0]        sym_d, tmds_q;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q <= MODE_CTRL;
        cd_q   <= '0;
        terc_q <= '0;
        qm_q   <= '0;
      end else if (ce) begin
        mode_q <= mode_e'(mode[2*i +: 2]);
        cd_q   <= cd[2*i +: 2];
        terc_q <= terc[4*i +: 4];
        qm_q   <= make_qm(vd[8*i +: 8]);
      end
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
      n1    = popcount8(qm_q[7:0]);
      diff  = {n1, 1'b0} - 5'd8;  // n1 - n0
      sym_d = CTRL_00;
      cnt_d = '0;
      unique case (mode_q)
        MODE_VIDEO: begin
          if ((cnt_q == 5'sd0) || (n1 == 4'd4)) begin
            sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d = cnt_q + (qm_q[8] ? diff : -diff);
          end else if (((cnt_q > 5'sd0) && (n1 > 4'd4)) ||
                       ((cnt_q < 5'sd0) && (n1 < 4'd4))) begin
            sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d = cnt_q + $signed({3'b000, qm_q[8], 1'b0}) - diff;
          end else begin
            sym_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d = cnt_q + diff - $signed({3'b000, ~qm_q[8], 1'b0});
          end
        end
        MODE_CTRL: begin
          unique case (cd_q)
            2'b00:   sym_d = CTRL_00;
            2'b01:   sym_d = CTRL_01;
            2'b10:   sym_d = CTRL_10;
            default: sym_d = CTRL_11;
          endcase
        end
        MODE_TERC: sym_d = terc4(terc_q);
        default:   sym_d = GUARD_SYM;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        tmds_q <= CTRL_00;
      end else if (ce) begin
        cnt_q  <= cnt_d;
        tmds_q <= sym_d;
      end
    end

    assign tmds[10*i +: 10] = tmds_q;
  end

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Self-checking bench: a rule-level model of the encoder predicts every lane each cycle;
// literal checks pin the model, and decode/disparity properties are checked on video runs.
module tb_tmds_multi_encoder;

  localparam int NCH = 4;

  localparam logic [9:0] CTRL_TAB [4] = '{10'b1101010100, 10'b0010101011,
                                          10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  localparam logic [9:0] RST_SYM = 10'b1101010100;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic [2*NCH-1:0]   mode;
  logic [8*NCH-1:0]   vd;
  logic [2*NCH-1:0]   cd;
  logic [4*NCH-1:0]   terc;
  logic [10*NCH-1:0]  tmds;
  logic [9:0]         tmds1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tmds_multi_encoder #(.NUM_CH(NCH)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .vd(vd), .cd(cd), .terc(terc), .tmds(tmds)
  );

  // Single-lane instance shares lane 0's stimulus.
  tmds_multi_encoder #(.NUM_CH(1)) u_dut1 (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode[1:0]), .vd(vd[7:0]), .cd(cd[1:0]),
    .terc(terc[3:0]), .tmds(tmds1)
  );

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_ok(input string name, input bit ok, input int val);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s @%0t: value %0d out of range", name, $time, val);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [9:0] sym;
    int         cnt;
  } enc_t;

  // Running disparity is tracked as the true cumulative ones-minus-zeros of emitted symbols.
  function automatic enc_t encode(input logic [1:0] m, input logic [7:0] v, input logic [1:0] c,
                                  input logic [3:0] t, input int cnt, input int lane);
    enc_t       r;
    logic [7:0] q;
    logic       xnr, q8, inv;
    int         n, d;
    r.cnt = 0;
    case (m)
      2'b00: r.sym = CTRL_TAB[c];
      2'b01: begin
        n    = $countones(v);
        xnr  = (n > 4) || (n == 4 && v[0] == 1'b0);
        q[0] = v[0];
        for (int k = 1; k < 8; k++) q[k] = xnr ? ~(q[k-1] ^ v[k]) : (q[k-1] ^ v[k]);
        q8 = !xnr;
        d  = 2 * $countones(q) - 8;
        if (cnt == 0 || d == 0)                       inv = !q8;
        else if ((cnt > 0 && d > 0) || (cnt < 0 && d < 0)) inv = 1'b1;
        else                                          inv = 1'b0;
        r.sym = {inv, q8, inv ? ~q : q};
        r.cnt = cnt + 2 * $countones(r.sym) - 10;
      end
      2'b10:   r.sym = TERC_TAB[t];
      default: r.sym = (lane % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int k = 1; k < 8; k++) o[k] = s[8] ? (d[k] ^ d[k-1]) : ~(d[k] ^ d[k-1]);
    return o;
  endfunction

  logic [1:0] s_mode [NCH];
  logic [7:0] s_vd   [NCH];
  logic [1:0] s_cd   [NCH];
  logic [3:0] s_terc [NCH];
  int         m_cnt  [NCH];
  logic [9:0] exp_sym[NCH];
  logic [1:0] o_mode [NCH];
  logic [7:0] o_vd   [NCH];
  logic       last_ce;
  enc_t       enc    [NCH];

  always_comb begin
    for (int l = 0; l < NCH; l++)
      enc[l] = encode(s_mode[l], s_vd[l], s_cd[l], s_terc[l], m_cnt[l], l);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ce <= 1'b0;
      for (int l = 0; l < NCH; l++) begin
        s_mode[l] <= 2'b00; s_vd[l] <= '0; s_cd[l] <= 2'b00; s_terc[l] <= '0;
        m_cnt[l] <= 0; exp_sym[l] <= RST_SYM; o_mode[l] <= 2'b00; o_vd[l] <= '0;
      end
    end else begin
      last_ce <= ce;
      if (ce) begin
        for (int l = 0; l < NCH; l++) begin
          exp_sym[l] <= enc[l].sym;
          m_cnt[l]   <= enc[l].cnt;
          o_mode[l]  <= s_mode[l];
          o_vd[l]    <= s_vd[l];
          s_mode[l]  <= mode[2*l +: 2];
          s_vd[l]    <= vd[8*l +: 8];
          s_cd[l]    <= cd[2*l +: 2];
          s_terc[l]  <= terc[4*l +: 4];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int rd [NCH];
  initial begin
    for (int l = 0; l < NCH; l++) rd[l] = 0;
    forever begin
      @(negedge clk);
      for (int l = 0; l < NCH; l++) begin
        check($sformatf("lane%0d", l), tmds[10*l +: 10], exp_sym[l]);
        if (rst) rd[l] = 0;
        else if (last_ce) begin
          if (o_mode[l] == 2'b01) begin
            rd[l] = rd[l] + 2 * $countones(tmds[10*l +: 10]) - 10;
            check_ok($sformatf("disparity%0d", l), rd[l] >= -10 && rd[l] <= 10, rd[l]);
            check($sformatf("decode%0d", l), {2'b00, decode(tmds[10*l +: 10])}, {2'b00, o_vd[l]});
          end else begin
            rd[l] = 0;
          end
        end
      end
      check("single_lane", tmds1, exp_sym[0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lane(input int l, input logic [1:0] m, input logic [7:0] v,
                          input logic [1:0] c, input logic [3:0] t);
    mode[2*l +: 2] = m;
    vd[8*l +: 8]   = v;
    cd[2*l +: 2]   = c;
    terc[4*l +: 4] = t;
  endtask

  task automatic set_all(input logic [1:0] m, input logic [1:0] c);
    for (int l = 0; l < NCH; l++) set_lane(l, m, 8'h00, c, 4'h0);
  endtask

  task automatic check_all(input string name, input logic [9:0] exp);
    for (int l = 0; l < NCH; l++) check(name, tmds[10*l +: 10], exp);
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    set_all(2'b00, 2'b00);
    tick(2);
    check_all("reset_state", RST_SYM);
    rst = 1'b0;
    tick(3);
    check_all("reset_hold", RST_SYM);

    // Video DC balance on lane 0 from cnt=0, then control, then video restarts at cnt=0.
    set_lane(0, 2'b01, 8'h00, 2'b00, 4'h0);
    tick(2);
    check("vid0_sym1", tmds[9:0], 10'b0100000000);
    tick(1);
    check("vid0_sym2", tmds[9:0], 10'b1111111111);
    set_lane(0, 2'b00, 8'h00, 2'b00, 4'h0);
    tick(1);
    check("vid0_sym3", tmds[9:0], 10'b0100000000);
    tick(1);
    set_lane(0, 2'b01, 8'h00, 2'b00, 4'h0);
    tick(2);
    check("vid0_restart", tmds[9:0], 10'b0100000000);

    // Control codes and guard band.
    set_all(2'b00, 2'b01); tick(2); check_all("ctrl01", 10'b0010101011);
    set_all(2'b00, 2'b10); tick(2); check_all("ctrl10", 10'b0101010100);
    set_all(2'b00, 2'b11); tick(2); check_all("ctrl11", 10'b1010101011);
    set_all(2'b11, 2'b00); tick(2);
    for (int l = 0; l < NCH; l++)
      check("guard", tmds[10*l +: 10], (l % 2 == 0) ? 10'b1011001100 : 10'b0100110011);

    // TERC4 sweep with per-lane offsets.
    for (int t = 0; t < 16; t++) begin
      for (int l = 0; l < NCH; l++) set_lane(l, 2'b10, 8'h00, 2'b00, 4'((t + 5 * l) % 16));
      tick(2);
      if (t == 0)  check("terc0",  tmds[9:0], 10'b1010011100);
      if (t == 8)  check("terc8",  tmds[9:0], 10'b1011001100);
      if (t == 15) check("terc15", tmds[9:0], 10'b1011000011);
    end

    // ce gating with changing video data.
    for (int c = 0; c < 24; c++) begin
      ce = (c % 2 == 0);
      for (int l = 0; l < NCH; l++) set_lane(l, 2'b01, 8'($urandom), 2'b00, 4'h0);
      tick(1);
    end
    ce = 1'b1;

    // Random regression with sticky per-lane modes so video runs are long.
    for (int c = 0; c < 3000; c++) begin
      ce = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < NCH; l++) begin
        logic [1:0] m;
        m = mode[2*l +: 2];
        if ($urandom_range(0, 15) == 0) m = 2'($urandom);
        set_lane(l, m, 8'($urandom), 2'($urandom), 4'($urandom));
      end
      tick(1);
    end

    // Asynchronous mid-stream reset during video traffic.
    ce = 1'b1;
    for (int l = 0; l < NCH; l++) set_lane(l, 2'b01, 8'($urandom), 2'b00, 4'h0);
    tick(4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all("async_reset", RST_SYM);
    check("async_reset_1ch", tmds1, RST_SYM);
    tick(1);
    set_all(2'b00, 2'b00);
    rst = 1'b0;
    tick(3);
    check_all("post_reset", RST_SYM);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
